// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline-side hazard inputs and controller enables/flushes/forward selects
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0] rs_id, rt_id, rs_ex, rt_ex, rd_ex, rd_mem, rd_wb;
  logic uses_rs_id, uses_rt_id, regwrite_ex, memread_ex, mul_start_ex, branch_taken_ex;
  logic regwrite_mem, regwrite_wb, clr_counters;
  logic pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush, mul_busy;
  logic [1:0] forward_a, forward_b;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  modport master (
    output rs_id, rt_id, rs_ex, rt_ex, rd_ex, rd_mem, rd_wb, uses_rs_id, uses_rt_id,
           regwrite_ex, memread_ex, mul_start_ex, branch_taken_ex, regwrite_mem, regwrite_wb, clr_counters,
    input  pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush, mul_busy,
           forward_a, forward_b, stall_cycles, flush_events
  );
  modport slave (
    input  rs_id, rt_id, rs_ex, rt_ex, rd_ex, rd_mem, rd_wb, uses_rs_id, uses_rt_id,
           regwrite_ex, memread_ex, mul_start_ex, branch_taken_ex, regwrite_mem, regwrite_wb, clr_counters,
    output pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush, mul_busy,
           forward_a, forward_b, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use / multiply / branch hazard control with forwarding and saturating perf counters
module pipe_hazard_ctrl #(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input logic             clk,
  input logic             rst_n,
  pipe_hazard_ctrl_if.slave h
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic br, mul_stall, lu_stall, st;

  function automatic logic [1:0] fwd(input logic [4:0] src);
    return (h.regwrite_mem && h.rd_mem != 5'd0 && h.rd_mem == src) ? 2'b10 :
           (h.regwrite_wb  && h.rd_wb  != 5'd0 && h.rd_wb  == src) ? 2'b01 : 2'b00;
  endfunction

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end

  // The release cycle (BUSY, cnt==0) ignores mul_start_ex, so back-to-back multiplies never overlap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (h.mul_start_ex && !h.branch_taken_ex) begin
        state_d = BUSY;
        cnt_d   = 4'(MUL_LATENCY - 1);
      end
    end else if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
    else state_d = IDLE;
  end

  // Branches are only honoured in IDLE; lu_stall here is already masked by the higher-priority causes.
  always_comb begin
    br        = h.branch_taken_ex && state_q == IDLE;
    mul_stall = rst_n && (state_q == IDLE ? h.mul_start_ex && !h.branch_taken_ex : cnt_q != 4'd0);
    lu_stall  = rst_n && !br && !mul_stall && h.memread_ex && h.regwrite_ex && h.rd_ex != 5'd0 &&
                ((h.uses_rs_id && h.rs_id == h.rd_ex) || (h.uses_rt_id && h.rt_id == h.rd_ex));
    st        = mul_stall || lu_stall;
    stall_d   = h.clr_counters ? '0 : stall_q + CNT_W'(st && !(&stall_q));
    flush_d   = h.clr_counters ? '0 : flush_q + CNT_W'(br && !(&flush_q));
  end

  assign h.pc_write     = !st;
  assign h.ifid_write   = !st;
  assign h.idex_write   = !mul_stall;
  assign h.ifid_flush   = br;
  assign h.idex_flush   = br || lu_stall;
  assign h.exmem_flush  = mul_stall;
  assign h.forward_a    = fwd(h.rs_ex);
  assign h.forward_b    = fwd(h.rt_ex);
  assign h.mul_busy     = state_q == BUSY;
  assign h.stall_cycles = stall_q;
  assign h.flush_events = flush_q;
endmodule
